// File: rtl/id_ex_decode_reg_if.sv
// rtl/id_ex_decode_reg_if.sv - ID-side inputs and ID/EX outputs of the decode register (ID_EX_illegal only with ILLEGAL_INSN_EN)
interface id_ex_decode_reg_if #(
    parameter int XLEN = 32
);
    logic [31:0]     IF_ID_IR;
    logic [XLEN-1:0] IF_ID_PC;
    logic            IF_ID_valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            ex_ready;
    logic            branch_taken;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_ready;
    logic [XLEN-1:0] ID_EX_A;
    logic [XLEN-1:0] ID_EX_BI;
    logic [XLEN-1:0] ID_EX_B;
    logic [XLEN-1:0] ID_EX_IMM;
    logic [XLEN-1:0] ID_EX_PC;
    logic [4:0]      ID_EX_RD;
    logic [1:0]      alu_type_sel;
    logic [2:0]      alucontrol;
    logic [6:0]      alucontrol7;
    logic            ID_EX_valid;
    logic            ID_EX_regwrite;
    logic            ID_EX_memread;
    logic            ID_EX_memwrite;
`ifdef ILLEGAL_INSN_EN
    logic            ID_EX_illegal;
`endif

    modport master (
        output IF_ID_IR, IF_ID_PC, IF_ID_valid, rs1_data, rs2_data, ex_ready, branch_taken,
        input  id_rs1, id_rs2, id_ready, ID_EX_A, ID_EX_BI, ID_EX_B, ID_EX_IMM, ID_EX_PC,
        input  ID_EX_RD, alu_type_sel, alucontrol, alucontrol7,
        input  ID_EX_valid, ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite
`ifdef ILLEGAL_INSN_EN
        , input ID_EX_illegal
`endif
    );

    modport slave (
        input  IF_ID_IR, IF_ID_PC, IF_ID_valid, rs1_data, rs2_data, ex_ready, branch_taken,
        output id_rs1, id_rs2, id_ready, ID_EX_A, ID_EX_BI, ID_EX_B, ID_EX_IMM, ID_EX_PC,
        output ID_EX_RD, alu_type_sel, alucontrol, alucontrol7,
        output ID_EX_valid, ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite
`ifdef ILLEGAL_INSN_EN
        , output ID_EX_illegal
`endif
    );
endinterface

// File: rtl/id_ex_decode_reg.sv
// rtl/id_ex_decode_reg.sv - RV32I decode and ID/EX pipeline register with load-use stall and flush (optional ILLEGAL_INSN_EN)
module id_ex_decode_reg #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_decode_reg_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SEL_ARITH  = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] bi;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [1:0]      alu_type_sel;
        logic [2:0]      alucontrol;
        logic [6:0]      alucontrol7;
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
`ifdef ILLEGAL_INSN_EN
        logic            illegal;
`endif
    } stage_t;

    stage_t          dec;
    stage_t          stage_d;
    stage_t          stage_q;
    logic [31:0]     ir;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            known;
    logic            wr;
    logic            rs1_used;
    logic            rs2_used;
    logic            hazard;

    // funct3 of ALU/I-ALU instructions to the ALU op encoding
    function automatic logic [2:0] alu_op(input logic [2:0] f3);
        alu_op = 3'b000;
        case (f3)
            3'b111:        alu_op = 3'b001;
            3'b110:        alu_op = 3'b010;
            3'b100:        alu_op = 3'b011;
            3'b101:        alu_op = 3'b100;
            3'b001:        alu_op = 3'b101;
            3'b010, 3'b011: alu_op = 3'b111;
            default:       alu_op = 3'b000;
        endcase
    endfunction

    // flush and load-use bubble kill the control bits but keep the data fields
    function automatic stage_t squash(input stage_t s);
        squash              = s;
        squash.valid        = 1'b0;
        squash.regwrite     = 1'b0;
        squash.memread      = 1'b0;
        squash.memwrite     = 1'b0;
        squash.alu_type_sel = 2'b00;
`ifdef ILLEGAL_INSN_EN
        squash.illegal      = 1'b0;
`endif
    endfunction

    assign ir     = bus.IF_ID_IR;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[11:7];

    assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

    // decode the IF/ID instruction into the fields the EX stage consumes
    always_comb begin
        dec    = '0;
        dec.a  = bus.rs1_data;
        dec.bi = bus.rs2_data;
        dec.b  = bus.rs2_data;
        dec.pc = bus.IF_ID_PC;
        dec.rd = rd;
        known  = 1'b1;
        wr     = 1'b0;
        case (opcode)
            OP_R: begin
                known             = (funct7 == 7'h00) || (funct7 == 7'h20);
                dec.alu_type_sel  = SEL_ARITH;
                dec.alucontrol    = alu_op(funct3);
                dec.alucontrol7   = funct7;
                wr                = 1'b1;
            end
            OP_I: begin
                dec.alu_type_sel = SEL_ARITH;
                dec.alucontrol   = alu_op(funct3);
                dec.bi           = imm_i;
                dec.imm          = imm_i;
                wr               = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_type_sel = SEL_ARITH;
                dec.bi           = imm_i;
                dec.imm          = imm_i;
                dec.memread      = 1'b1;
                wr               = 1'b1;
            end
            OP_STORE: begin
                dec.alu_type_sel = SEL_ARITH;
                dec.bi           = imm_s;
                dec.imm          = imm_s;
                dec.memwrite     = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_type_sel = SEL_BRANCH;
                dec.alucontrol   = funct3;
                dec.imm          = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                dec.alu_type_sel = SEL_ARITH;
                dec.a            = (opcode == OP_LUI) ? '0 : bus.IF_ID_PC;
                dec.bi           = imm_u;
                dec.imm          = imm_u;
                wr               = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                dec.alu_type_sel = SEL_ARITH;
                dec.a            = bus.IF_ID_PC;
                dec.bi           = XLEN'(4);
                dec.imm          = (opcode == OP_JAL) ? imm_j : imm_i;
                wr               = 1'b1;
            end
            default: known = 1'b0;
        endcase
        if (!(bus.IF_ID_valid && known)) begin
            dec.alu_type_sel = 2'b00;
            dec.alucontrol   = 3'b000;
            dec.alucontrol7  = 7'h00;
            dec.memread      = 1'b0;
            dec.memwrite     = 1'b0;
            wr               = 1'b0;
        end
        dec.regwrite = wr && (rd != 5'd0);
`ifdef ILLEGAL_INSN_EN
        dec.valid    = bus.IF_ID_valid;
        dec.illegal  = bus.IF_ID_valid && !known;
`else
        dec.valid    = bus.IF_ID_valid && known;
`endif
    end

    // load-use detection against the load currently sitting in ID/EX
    always_comb begin
        rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        hazard   = stage_q.valid && stage_q.memread && (stage_q.rd != 5'd0) && bus.IF_ID_valid &&
                   ((rs1_used && (stage_q.rd == ir[19:15])) || (rs2_used && (stage_q.rd == ir[24:20])));
    end

    // next ID/EX contents: flush, then hold, then bubble, then load
    always_comb begin
        stage_d = stage_q;
        if (bus.branch_taken) begin
            stage_d = squash(stage_q);
        end else if (!bus.ex_ready) begin
            stage_d = stage_q;
        end else if (hazard) begin
            stage_d = squash(stage_q);
        end else begin
            stage_d = dec;
        end
    end

    // ID/EX register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.id_rs1         = ir[19:15];
    assign bus.id_rs2         = ir[24:20];
    assign bus.id_ready       = rst_n && (bus.branch_taken || (bus.ex_ready && !hazard));
    assign bus.ID_EX_A        = stage_q.a;
    assign bus.ID_EX_BI       = stage_q.bi;
    assign bus.ID_EX_B        = stage_q.b;
    assign bus.ID_EX_IMM      = stage_q.imm;
    assign bus.ID_EX_PC       = stage_q.pc;
    assign bus.ID_EX_RD       = stage_q.rd;
    assign bus.alu_type_sel   = stage_q.alu_type_sel;
    assign bus.alucontrol     = stage_q.alucontrol;
    assign bus.alucontrol7    = stage_q.alucontrol7;
    assign bus.ID_EX_valid    = stage_q.valid;
    assign bus.ID_EX_regwrite = stage_q.regwrite;
    assign bus.ID_EX_memread  = stage_q.memread;
    assign bus.ID_EX_memwrite = stage_q.memwrite;
`ifdef ILLEGAL_INSN_EN
    assign bus.ID_EX_illegal  = stage_q.illegal;
`endif
endmodule

// File: tb/tb_id_ex_decode_reg.sv
// tb/tb_id_ex_decode_reg.sv - directed bench for id_ex_decode_reg
module tb_id_ex_decode_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;

    id_ex_decode_reg_if #(.XLEN(32)) bus ();
    id_ex_decode_reg #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // {alu_type_sel, alucontrol, alucontrol7, RD, valid, regwrite, memread, memwrite}
    logic [20:0]  ctl;
    logic [20:0]  e;
    logic [159:0] data;
    logic [2:0]   map_exp [8];
    assign ctl  = {bus.alu_type_sel, bus.alucontrol, bus.alucontrol7, bus.ID_EX_RD,
                   bus.ID_EX_valid, bus.ID_EX_regwrite, bus.ID_EX_memread, bus.ID_EX_memwrite};
    assign data = {bus.ID_EX_A, bus.ID_EX_BI, bus.ID_EX_B, bus.ID_EX_IMM, bus.ID_EX_PC};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.IF_ID_IR = 32'h002081B3; bus.IF_ID_PC = 32'h100; bus.IF_ID_valid = 1'b1;
        bus.rs1_data = 32'd5; bus.rs2_data = 32'd7; bus.ex_ready = 1'b1; bus.branch_taken = 1'b0;
        step(); step();
        n_cmp++; if (ctl !== 21'h0) begin n_fail++; $display("FAIL reset_ctl got %h want 0", ctl); end
        n_cmp++; if (data !== 160'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data); end
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_id_ready got %b want 0", bus.id_ready); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_id_ready got %b want 1", bus.id_ready); end
    endtask

    task automatic test_alu();
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd3, 4'b1100};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL add_ctl got %h want %h", ctl, e); end
        n_cmp++; if (bus.ID_EX_A !== 32'd5 || bus.ID_EX_BI !== 32'd7) begin n_fail++; $display("FAIL add_ops got %h/%h want 5/7", bus.ID_EX_A, bus.ID_EX_BI); end
        n_cmp++; if (bus.ID_EX_PC !== 32'h100) begin n_fail++; $display("FAIL add_pc got %h want 100", bus.ID_EX_PC); end
        bus.IF_ID_IR = 32'h40208233;
        step();
        e = {2'b01, 3'b000, 7'h20, 5'd4, 4'b1100};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL sub_ctl got %h want %h", ctl, e); end
        bus.IF_ID_IR = 32'hFFF00093;
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd1, 4'b1100};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL addi_ctl got %h want %h", ctl, e); end
        n_cmp++; if (bus.ID_EX_BI !== 32'hFFFFFFFF || bus.ID_EX_IMM !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm got %h/%h want ffffffff", bus.ID_EX_BI, bus.ID_EX_IMM); end
    endtask

    task automatic test_alu_map();
        map_exp = '{3'b000, 3'b101, 3'b111, 3'b111, 3'b011, 3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 8; i++) begin
            logic [2:0] f3;
            f3 = 3'(i);
            bus.IF_ID_IR = {12'h405, 5'd2, f3, 5'd1, 7'b0010011};
            step();
            e = {2'b01, map_exp[i], 7'h00, 5'd1, 4'b1100};
            n_cmp++; if (ctl !== e || bus.ID_EX_BI !== 32'h405) begin n_fail++; $display("FAIL alu_map f3=%0d got %h/%h want %h/405", i, ctl, bus.ID_EX_BI, e); end
        end
    endtask

    task automatic test_load_use();
        bus.rs1_data = 32'h1000;
        bus.IF_ID_IR = 32'h0000A283;
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd5, 4'b1110};
        n_cmp++; if (ctl !== e || bus.ID_EX_BI !== 32'd0) begin n_fail++; $display("FAIL lw_ctl got %h/%h want %h/0", ctl, bus.ID_EX_BI, e); end
        bus.IF_ID_IR = 32'h00528333;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_stall got %b want 0", bus.id_ready); end
        step();
        e = {2'b00, 3'b000, 7'h00, 5'd5, 4'b0000};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL bubble_ctl got %h want %h", ctl, e); end
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_release got %b want 1", bus.id_ready); end
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd6, 4'b1100};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL add_after_bubble got %h want %h", ctl, e); end
        bus.IF_ID_IR = 32'h0000A283;
        step();
        bus.IF_ID_IR = 32'h000282B7;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL lui_no_hazard got %b want 1", bus.id_ready); end
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd5, 4'b1100};
        n_cmp++; if (ctl !== e || bus.ID_EX_A !== 32'd0 || bus.ID_EX_BI !== 32'h00028000) begin n_fail++; $display("FAIL lui got %h/%h/%h want %h/0/28000", ctl, bus.ID_EX_A, bus.ID_EX_BI, e); end
    endtask

    task automatic test_upper_jump();
        bus.IF_ID_PC = 32'h200;
        bus.IF_ID_IR = 32'h00001397;
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd7, 4'b1100};
        n_cmp++; if (ctl !== e || bus.ID_EX_A !== 32'h200 || bus.ID_EX_BI !== 32'h1000) begin n_fail++; $display("FAIL auipc got %h/%h/%h want %h/200/1000", ctl, bus.ID_EX_A, bus.ID_EX_BI, e); end
        bus.IF_ID_IR = 32'h010000EF;
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd1, 4'b1100};
        n_cmp++; if (ctl !== e || bus.ID_EX_A !== 32'h200 || bus.ID_EX_BI !== 32'd4 || bus.ID_EX_IMM !== 32'd16) begin n_fail++; $display("FAIL jal got %h/%h/%h/%h want %h/200/4/10", ctl, bus.ID_EX_A, bus.ID_EX_BI, bus.ID_EX_IMM, e); end
        bus.IF_ID_IR = 32'h00C100E7;
        step();
        n_cmp++; if (ctl !== e || bus.ID_EX_BI !== 32'd4 || bus.ID_EX_IMM !== 32'd12) begin n_fail++; $display("FAIL jalr got %h/%h/%h want %h/4/c", ctl, bus.ID_EX_BI, bus.ID_EX_IMM, e); end
    endtask

    task automatic test_store();
        bus.rs2_data = 32'hCAFE;
        bus.IF_ID_IR = 32'hFE20AE23;
        step();
        e = {2'b01, 3'b000, 7'h00, 5'h1C, 4'b1001};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL sw_ctl got %h want %h", ctl, e); end
        n_cmp++; if (bus.ID_EX_BI !== 32'hFFFFFFFC || bus.ID_EX_B !== 32'hCAFE) begin n_fail++; $display("FAIL sw_data got %h/%h want fffffffc/cafe", bus.ID_EX_BI, bus.ID_EX_B); end
    endtask

    task automatic test_bubble_cases();
        bus.IF_ID_IR = 32'h00100013;
        step();
        e = {2'b01, 3'b000, 7'h00, 5'd0, 4'b1000};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL rd_x0 got %h want %h", ctl, e); end
        bus.IF_ID_IR = 32'h0000007F;
        step();
`ifdef ILLEGAL_INSN_EN
        e = {2'b00, 3'b000, 7'h00, 5'd0, 4'b1000};
        n_cmp++; if (bus.ID_EX_illegal !== 1'b1) begin n_fail++; $display("FAIL unknown_illegal got %b want 1", bus.ID_EX_illegal); end
`else
        e = {2'b00, 3'b000, 7'h00, 5'd0, 4'b0000};
`endif
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL unknown_op got %h want %h", ctl, e); end
        bus.IF_ID_IR = 32'h022081B3;
        step();
`ifdef ILLEGAL_INSN_EN
        e = {2'b00, 3'b000, 7'h00, 5'd3, 4'b1000};
        n_cmp++; if (bus.ID_EX_illegal !== 1'b1) begin n_fail++; $display("FAIL funct7_illegal got %b want 1", bus.ID_EX_illegal); end
`else
        e = {2'b00, 3'b000, 7'h00, 5'd3, 4'b0000};
`endif
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL bad_funct7 got %h want %h", ctl, e); end
        bus.IF_ID_IR = 32'h002081B3;
        bus.IF_ID_valid = 1'b0;
        step();
        e = {2'b00, 3'b000, 7'h00, 5'd3, 4'b0000};
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL invalid_in got %h want %h", ctl, e); end
        bus.IF_ID_valid = 1'b1;
    endtask

    task automatic test_branch_flush();
        bus.rs1_data = 32'd5; bus.rs2_data = 32'd7;
        bus.IF_ID_IR = 32'h00208463;
        step();
        e = {2'b10, 3'b000, 7'h00, 5'd8, 4'b1000};
        n_cmp++; if (ctl !== e || bus.ID_EX_IMM !== 32'd8) begin n_fail++; $display("FAIL beq got %h/%h want %h/8", ctl, bus.ID_EX_IMM, e); end
        n_cmp++; if (bus.ID_EX_A !== 32'd5 || bus.ID_EX_BI !== 32'd7) begin n_fail++; $display("FAIL beq_ops got %h/%h want 5/7", bus.ID_EX_A, bus.ID_EX_BI); end
        bus.branch_taken = 1'b1; bus.ex_ready = 1'b0;
        bus.IF_ID_IR = 32'h002081B3; bus.rs1_data = 32'h77;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_id_ready got %b want 1", bus.id_ready); end
        step();
        e = {2'b00, 3'b000, 7'h00, 5'd8, 4'b0000};
        n_cmp++; if (ctl !== e || bus.ID_EX_A !== 32'd5) begin n_fail++; $display("FAIL flush got %h/%h want %h/5", ctl, bus.ID_EX_A, e); end
        bus.branch_taken = 1'b0; bus.ex_ready = 1'b1;
    endtask

    task automatic test_hold_reset();
        bus.IF_ID_IR = 32'h002081B3; bus.rs1_data = 32'h11;
        step();
        bus.ex_ready = 1'b0;
        e = {2'b01, 3'b000, 7'h00, 5'd3, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            bus.IF_ID_IR = (i == 0) ? 32'h40208233 : (i == 1) ? 32'hFFF00093 : 32'h0000A283;
            bus.rs1_data = 32'h99 + 32'(i);
            #1;
            n_cmp++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_id_ready cyc%0d got %b want 0", i, bus.id_ready); end
            step();
            n_cmp++; if (ctl !== e || bus.ID_EX_A !== 32'h11) begin n_fail++; $display("FAIL hold cyc%0d got %h/%h want %h/11", i, ctl, bus.ID_EX_A, e); end
        end
        rst_n = 1'b0;
        step();
        n_cmp++; if (ctl !== 21'h0 || data !== 160'h0) begin n_fail++; $display("FAIL reset_in_hold got %h/%h want 0/0", ctl, data); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_alu_map();
        test_load_use();
        test_upper_jump();
        test_store();
        test_bubble_cases();
        test_branch_flush();
        test_hold_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
